// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM state encoding and the fixed datapath widths.
package mul_seq_ctrl_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

    // RUN cycle index after which the multiply is complete (32 RUN cycles).
    localparam logic [5:0] CNT_LAST = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mul_seq_ctrl_pkg

// File: rtl/mul_seq_ctrl_fa_32bit.sv
// FA_32bit: 32-bit ripple-carry adder built from a chain of full-adder cells.
// Carry-out is exported so the multiplier never loses the top bit of a partial sum.
module FA_32bit
    import mul_seq_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin,
    output logic [OP_W-1:0] sum,
    output logic            cout
);

    logic [OP_W:0] carry;

    assign carry[0] = cin;

    // One full-adder cell per bit, carry rippling upward.
    generate
        for (genvar gi = 0; gi < OP_W; gi++) begin : g_fa
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[OP_W];

endmodule : FA_32bit

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32 -> 64 unsigned sequential shift-add multiplier.
// One operand pair is accepted in IDLE, 32 RUN cycles shift the multiplier
// out of Q while the product high half accumulates in P_hi, and DONE holds
// {P_hi, Q} until the consumer takes it.
// Compile-time option: MUL_ZERO_SKIP_EN -- when defined, a zero operand
// bypasses RUN and the result (0) is presented in DONE right after acceptance.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    state_t          state_reg, state_next;
    logic [OP_W-1:0] m_reg, m_next;
    logic [OP_W-1:0] q_reg, q_next;
    logic [OP_W-1:0] p_hi_reg, p_hi_next;
    logic [5:0]      count_reg, count_next;

    logic [OP_W-1:0] addend;
    logic [OP_W-1:0] sum;
    logic            cout;

    // Multiplicand is added only when the current multiplier LSB is set.
    assign addend = q_reg[0] ? m_reg : '0;

    FA_32bit u_adder (
        .a    (p_hi_reg),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            q_reg     <= '0;
            p_hi_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            q_reg     <= q_next;
            p_hi_reg  <= p_hi_next;
            count_reg <= count_next;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        q_next     = q_reg;
        p_hi_next  = p_hi_reg;
        count_next = count_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_next     = a;
                    q_next     = b;
                    p_hi_next  = '0;
                    count_next = '0;
`ifdef MUL_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        // Result is trivially zero: clear Q so {P_hi,Q} reads 0.
                        q_next     = '0;
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
`else
                    state_next = RUN;
`endif
                end
            end

            RUN: begin
                busy       = 1'b1;
                // Shift the 65-bit {cout, sum, Q} right by one; sum LSB enters Q.
                p_hi_next  = {cout, sum[OP_W-1:1]};
                q_next     = {sum[0], q_reg[OP_W-1:1]};
                count_next = count_reg + 6'd1;
                if (count_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign product = {p_hi_reg, q_reg};

endmodule : mul_seq_ctrl

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl: directed corner cases plus randomized operand
// pairs, each result compared with a plain 64-bit multiply of the accepted
// operands. Inputs change and outputs are sampled on the falling edge.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Edges from the accepting edge until out_valid is visible.
    localparam int FULL_LAT = 32;
`ifdef MUL_ZERO_SKIP_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 32;
`endif

    mul_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one operand pair, wait for the result, hold it for 'hold'
    // cycles with out_ready low, then release it.
    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                         input int hold, input bit junk, input string tag);
        logic [63:0] exp_prod;
        int          exp_lat;
        int          n;
        exp_prod = {32'b0, oa} * {32'b0, ob};
        exp_lat  = ((oa == 0) || (ob == 0)) ? ZERO_LAT : FULL_LAT;

        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = oa;
        b         = ob;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = junk;
        n = 0;
        while (!out_valid && n < 100) begin
            checks++;
            assert (in_ready === 1'b0 && busy === 1'b1) else begin
                errors++;
                $error("FAIL %s.run_flags observed=%0b%0b expected=01 at n=%0d", tag, in_ready, busy, n);
            end
            if (junk) begin
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".product"}, product, exp_prod);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            assert (out_valid === 1'b1 && in_ready === 1'b0 && product === exp_prod) else begin
                errors++;
                $error("FAIL %s.hold ov=%0b ir=%0b product=%0h expected ov=1 ir=0 product=%0h",
                       tag, out_valid, in_ready, product, exp_prod);
            end
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
        $display("op %s a=%08h b=%08h product=%016h latency=%0d", tag, oa, ob, product, n);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (3) @(negedge clk);
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.busy",      64'(busy),      64'd0);
        check("reset.product",   product,        64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset.in_ready", 64'(in_ready), 64'd1);

        do_op(32'd3, 32'd5, 0, 1'b0, "small");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, "all_ones");
        do_op(32'h12345678, 32'h9ABCDEF0, 10, 1'b0, "held");
        do_op(32'd0, 32'h55, 0, 1'b0, "zero_a");
        do_op(32'h55, 32'd0, 1, 1'b0, "zero_b");
        do_op(32'hDEADBEEF, 32'h00C0FFEE, 2, 1'b1, "junk_in");

        // Abort an operation mid-RUN with reset.
        in_valid = 1'b1;
        a        = 32'hCAFEF00D;
        b        = 32'h87654321;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (n < 15) begin
            @(negedge clk);
            n++;
        end
        check("abort.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.in_ready",  64'(in_ready),  64'd1);
        check("abort.busy",      64'(busy),      64'd0);
        check("abort.product",   product,        64'd0);
        $display("op abort reset at RUN cycle 15");
        do_op(32'd7, 32'd9, 0, 1'b0, "after_abort");

        // Randomized operand pairs, occasionally with zero or extreme values.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                default: ;
            endcase
            do_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mul_seq_ctrl

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 32 bits and product width at 64 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  operand pair offered.
REQ-005 in_ready  out  1  block can accept an operand pair.
REQ-006 a  in  32  multiplicand, unsigned.
REQ-007 b  in  32  multiplier, unsigned.
REQ-008 out_valid  out  1  product available.
REQ-009 out_ready  in  1  consumer takes product.
REQ-010 product  out  64  unsigned a*b.
REQ-011 busy  out  1  high in RUN state.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready, latch M=a, Q=b, P_hi=0, count=0, go to RUN.
REQ-014 RUN: each cycle, the shared 32-bit adder SHALL compute P_hi + (Q[0] ? M : 0) with carry-in 0, giving sum and cout.
REQ-015 RUN update: P_hi <= {cout, sum[31:1]}, Q <= {sum[0], Q[31:1]}, count <= count+1.
REQ-016 The 6-bit count SHALL be used; after the RUN cycle in which count==31, the FSM SHALL go to DONE (32 RUN cycles).
REQ-017 product SHALL equal {P_hi, Q}; out_valid SHALL be 1 only in DONE.
REQ-018 Latency: out_valid SHALL rise on the 32nd rising edge after the accepting edge.
REQ-019 DONE: product SHALL be held stable while out_valid=1 and out_ready=0.
REQ-020 On out_valid&&out_ready, go to IDLE; in_ready SHALL rise the following cycle, with no same-cycle accept.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid, a and b SHALL be ignored there.
REQ-022 Adder carry-in SHALL be tied 0; cout SHALL never be lost, so the result is exact for all 2^64 operand pairs.

Reset
REQ-023 On rst: state=IDLE, in_ready=1 from the first post-reset cycle, out_valid=0, busy=0, product=0, count=0.
REQ-024 rst SHALL take priority over every handshake; an operation in RUN or DONE SHALL be discarded with no output.

Configuration
REQ-025 The macro MUL_ZERO_SKIP_EN SHALL be the only compile-time option.
REQ-026 With MUL_ZERO_SKIP_EN defined: on acceptance with a==0 or b==0, the FSM SHALL go directly to DONE with product=0, setting out_valid on the next edge (latency 1).
REQ-027 Without MUL_ZERO_SKIP_EN: zero operands SHALL take the full 32-cycle RUN path.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/RUN/DONE), OP_W=32, PROD_W=64 and CNT_LAST=31.
REQ-029 The adder SHALL be one instance of the team's 32-bit ripple full adder FA_32bit, the only sub-module.
REQ-030 FSM, M/Q/P_hi registers and count SHALL live in mul_seq_ctrl.

Verification
REQ-031 a=3, b=5, out_ready=1 -> out_valid high exactly 32 cycles after accept, product=64'h0F.
REQ-032 a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001; checks that carry-out propagates.
REQ-033 a=32'h12345678, b=32'h9ABCDEF0, out_ready=0 for 10 cycles after out_valid -> product held stable and in_ready=0 throughout; on release, in_ready=1 the next cycle.
REQ-034 rst pulsed at RUN cycle 15 -> next cycle IDLE, out_valid=0, in_ready=1; a new 7*9 completes with product=63.
REQ-035 a=0, b=32'h55 -> with MUL_ZERO_SKIP_EN, product=0 one cycle after accept; without it, product=0 after 32 cycles.
REQ-036 in_valid held high with changing a/b during RUN -> result reflects only the operands latched at accept.
